multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- An FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, holding memory requests until ihit/dhit.
- It gates PC and register-file writes per state and latches the decoded controls for the whole instruction.
- It adds a parametrised memory-wait timeout and optional LL/SC link tracking; it sits between the datapath and the cache/memory interface.

Parameters:
- WORD_W, 32, instruction/address width.
- WAIT_LIMIT, 64, max consecutive cycles waiting for ihit/dhit before timeout; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; must hold WAIT_LIMIT.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, synchronous, active-low.
- instruction  in  WORD_W  instruction word from imemload.
- ihit  in  1  instruction fetch complete.
- dhit  in  1  data access complete.
- daddr  in  WORD_W  effective data address (ALU result).
- ccinv  in  1  coherence invalidate strobe.
- ccsnoopaddr  in  WORD_W  invalidated address.
- iREN  out  1  instruction read request.
- dREN, dWEN  out  1 each  data read/write request.
- IRWEN  out  1  load instruction register.
- PCWEN  out  1  PC update strobe.
- RegWEN  out  1  register-file write.
- MemtoReg  out  2  writeback select: 0 ALU, 1 memory, 2 sc_result.
- ALUsrc  out  2  0 rt, 1 sign-ext imm, 2 zero-ext imm.
- Regdst  out  2  0 rd, 1 rt, 2 r31.
- jsel  out  3  PC source: 0 PC+4, 1 J, 2 JR, 3 JAL, 4 branch, 5 LUI.
- aluop  out  4  aluop_t.
- bne  out  1  branch-on-not-equal.
- sc_result  out  1  SC success value for writeback.
- halt  out  1  sticky halt.
- timeout_err  out  1  sticky memory-wait timeout.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (nRST low at a CLK edge):
  - state=FETCH, wait counter=0, link_valid=0, decode registers cleared (NOP).
  - halt=0, timeout_err=0, sc_result=0.
  - All strobes are 0 during the reset cycle.
  - Reset mid-instruction aborts with no RegWEN/PCWEN/dWEN.
- Outputs are decoded from state plus registered instruction fields. aluop, ALUsrc, Regdst and jsel use the single-cycle opcode/funct mapping, including SLTIU as ALU_SLT.
- FETCH:
  - iREN=1 until ihit.
  - On ihit: IRWEN=1, instruction latched into decode regs, next state DECODE.
- DECODE (1 cycle):
  - HALT goes to HALTED.
  - J/JAL/JR: PCWEN=1 with jsel=1/3/2. JAL also asserts RegWEN with Regdst=2 and goes to FETCH. J/JR go straight to FETCH.
  - LUI: RegWEN=1, PCWEN=1, jsel=5, then FETCH.
  - All other instructions go to EXEC.
- EXEC (1 cycle):
  - BEQ/BNE: PCWEN=1, jsel=4, bne per opcode, then FETCH.
  - LW/LL/SW/SC go to MEM.
  - ALU ops go to WB.
- MEM:
  - Loads hold dREN=1 and stores hold dWEN=1 until dhit; requests are stable while waiting.
  - On dhit, loads go to WB; SW does PCWEN=1 and goes to FETCH.
- WB (1 cycle): RegWEN=1 (not for JR), PCWEN=1, jsel=0, then FETCH.
- HALTED: absorbing until reset. halt=1, all strobes 0.
- Wait counter:
  - Increments each FETCH/MEM cycle without the matching hit; clears on hit or state change.
  - When it equals WAIT_LIMIT (WAIT_LIMIT≠0), set timeout_err and halt and go to HALTED. The request drops that same cycle.
  - A hit arriving in the limit cycle wins: no timeout.
- Unknown opcode: treated as NOP through EXEC, then WB with RegWEN=0.

Optional Feature:
- Macro: LLSC_EN.
- Defined: LL on dhit sets link_addr=daddr and link_valid=1.
- SC in EXEC:
  - If link_valid and daddr==link_addr: go to MEM with dWEN, then WB with MemtoReg=2, sc_result=1, and clear link_valid.
  - Otherwise skip MEM and go to WB with sc_result=0, no dWEN.
- link_valid clears on ccinv with ccsnoopaddr==link_addr, or on this core's SW dhit to link_addr.
- If invalidate and LL set happen in the same cycle, set wins.
- Not defined: LL behaves as LW; SC behaves as SW then WB with MemtoReg=2 and sc_result=1. ccinv/ccsnoopaddr are ignored.

Test Plan:
- ADDU with ihit after 3 cycles:
  - iREN high 3 cycles, then IRWEN.
  - State sequence FETCH→DECODE→EXEC→WB→FETCH.
  - RegWEN=1 only in WB, aluop=ALU_ADD, Regdst=0.
- LW with dhit delayed 5 cycles: dREN held 5 cycles with stable address, then WB with MemtoReg=1, RegWEN=1, PCWEN=1.
- BNE: PCWEN=1 in EXEC with jsel=4, bne=1, RegWEN never asserted; JAL: PCWEN and RegWEN in DECODE, Regdst=2, jsel=3.
- WAIT_LIMIT=4, ihit never asserted: after 4 wait cycles timeout_err=1, halt=1, state=HALTED, iREN=0; nRST low for one edge clears all and returns to FETCH.
- LLSC_EN, success case: LL 0x100, then SC 0x100 gives dWEN and sc_result=1.
- LLSC_EN, failure case: LL 0x100, ccinv with ccsnoopaddr=0x100, then SC 0x100 gives no dWEN, sc_result=0, RegWEN=1.
- HALT opcode: DECODE→HALTED; halt stays 1 and all strobes 0 for 10+ cycles despite ihit/dhit toggling.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory-wait timeout,
// and LL/SC link tracking when the LLSC_EN macro is defined.
module multicycle_control_unit #(
  parameter int WORD_W     = 32,
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_W      = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instruction,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [WORD_W-1:0] daddr,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccsnoopaddr,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              IRWEN,
  output logic              PCWEN,
  output logic              RegWEN,
  output logic [1:0]        MemtoReg,
  output logic [1:0]        ALUsrc,
  output logic [1:0]        Regdst,
  output logic [2:0]        jsel,
  output logic [3:0]        aluop,
  output logic              bne,
  output logic              sc_result,
  output logic              halt,
  output logic              timeout_err,
  output logic [2:0]        state
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALTED = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
                         OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e,
                         OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b, OP_LL = 6'h30,
                         OP_SC = 6'h38, OP_HALT = 6'h3f;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a,
                         FN_SLTU = 6'h2b;

  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                         ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);
  localparam bit TIMEOUT_ON = (WAIT_LIMIT != 0);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [5:0]       op_reg, funct_reg;
  logic             halt_reg, timeout_err_reg, sc_result_reg;

  logic [3:0] aluop_dec;
  logic [1:0] alusrc_dec, regdst_dec, memtoreg_dec;
  logic [2:0] jsel_dec;
  logic       writes_reg;
  logic       iren_c, dren_c, dwen_c, irwen_c, pcwen_c, regwen_c, timeout_fire;
  logic       is_load, is_store, is_sc, is_sw, is_ll, is_direct, sc_ok, at_limit, hit_now;

  // Opcode/funct to datapath controls, same mapping as the single-cycle decoder.
  always_comb begin
    aluop_dec    = ALU_ADD;
    alusrc_dec   = 2'd0;
    regdst_dec   = 2'd0;
    jsel_dec     = 3'd0;
    memtoreg_dec = 2'd0;
    writes_reg   = 1'b0;
    case (op_reg)
      OP_RTYPE: begin
        writes_reg = 1'b1;
        case (funct_reg)
          FN_SLL:          aluop_dec = ALU_SLL;
          FN_SRL:          aluop_dec = ALU_SRL;
          FN_ADD, FN_ADDU: aluop_dec = ALU_ADD;
          FN_SUB, FN_SUBU: aluop_dec = ALU_SUB;
          FN_AND:          aluop_dec = ALU_AND;
          FN_OR:           aluop_dec = ALU_OR;
          FN_XOR:          aluop_dec = ALU_XOR;
          FN_NOR:          aluop_dec = ALU_NOR;
          FN_SLT:          aluop_dec = ALU_SLT;
          FN_SLTU:         aluop_dec = ALU_SLTU;
          FN_JR: begin
            jsel_dec   = 3'd2;
            writes_reg = 1'b0;
          end
          default:         writes_reg = 1'b0;
        endcase
      end
      OP_J:              jsel_dec = 3'd1;
      OP_JAL: begin
        jsel_dec   = 3'd3;
        regdst_dec = 2'd2;
        writes_reg = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        aluop_dec = ALU_SUB;
        jsel_dec  = 3'd4;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        aluop_dec  = (op_reg == OP_SLTI || op_reg == OP_SLTIU) ? ALU_SLT : ALU_ADD;
        alusrc_dec = 2'd1;
        regdst_dec = 2'd1;
        writes_reg = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        aluop_dec  = (op_reg == OP_ANDI) ? ALU_AND : (op_reg == OP_ORI) ? ALU_OR : ALU_XOR;
        alusrc_dec = 2'd2;
        regdst_dec = 2'd1;
        writes_reg = 1'b1;
      end
      OP_LUI: begin
        alusrc_dec = 2'd2;
        regdst_dec = 2'd1;
        jsel_dec   = 3'd5;
        writes_reg = 1'b1;
      end
      OP_LW, OP_LL, OP_SC: begin
        alusrc_dec   = 2'd1;
        regdst_dec   = 2'd1;
        memtoreg_dec = (op_reg == OP_SC) ? 2'd2 : 2'd1;
        writes_reg   = 1'b1;
      end
      OP_SW:             alusrc_dec = 2'd1;
      default: ;
    endcase
  end

  assign is_ll     = (op_reg == OP_LL);
  assign is_sc     = (op_reg == OP_SC);
  assign is_sw     = (op_reg == OP_SW);
  assign is_load   = (op_reg == OP_LW) || is_ll;
  assign is_store  = is_sw || is_sc;
  assign is_direct = (jsel_dec == 3'd1) || (jsel_dec == 3'd2) || (jsel_dec == 3'd3) ||
                     (jsel_dec == 3'd5);
  assign at_limit  = TIMEOUT_ON && (wait_cnt_reg == LIMIT);
  assign hit_now   = ((state_reg == S_FETCH) && ihit) || ((state_reg == S_MEM) && dhit);

`ifdef LLSC_EN
  logic              link_valid_reg;
  logic [WORD_W-1:0] link_addr_reg;
  logic [19:0]       unused_bits;
  assign sc_ok       = link_valid_reg && (daddr == link_addr_reg);
  assign unused_bits = instruction[25:6];
`else
  logic unused_bits;
  assign sc_ok       = 1'b1;
  assign unused_bits = ^{instruction[25:6], daddr, ccinv, ccsnoopaddr};
`endif

  always_comb begin
    state_next   = state_reg;
    iren_c       = 1'b0;
    dren_c       = 1'b0;
    dwen_c       = 1'b0;
    irwen_c      = 1'b0;
    pcwen_c      = 1'b0;
    regwen_c     = 1'b0;
    timeout_fire = 1'b0;
    case (state_reg)
      S_FETCH: begin
        iren_c = !at_limit;
        if (ihit) begin
          irwen_c    = 1'b1;
          state_next = S_DECODE;
        end else if (at_limit) begin
          timeout_fire = 1'b1;
          state_next   = S_HALTED;
        end
      end
      S_DECODE: begin
        if (op_reg == OP_HALT) begin
          state_next = S_HALTED;
        end else if (is_direct) begin
          pcwen_c    = 1'b1;
          regwen_c   = writes_reg;
          state_next = S_FETCH;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (jsel_dec == 3'd4) begin
          pcwen_c    = 1'b1;
          state_next = S_FETCH;
        end else if ((is_load || is_store) && !(is_sc && !sc_ok)) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        dren_c = is_load && !at_limit;
        dwen_c = is_store && !at_limit;
        if (dhit) begin
          pcwen_c    = is_sw;
          state_next = is_sw ? S_FETCH : S_WB;
        end else if (at_limit) begin
          timeout_fire = 1'b1;
          state_next   = S_HALTED;
        end
      end
      S_WB: begin
        regwen_c   = writes_reg;
        pcwen_c    = 1'b1;
        state_next = S_FETCH;
      end
      S_HALTED: ;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg       <= S_FETCH;
      wait_cnt_reg    <= '0;
      op_reg          <= 6'd0;
      funct_reg       <= 6'd0;
      halt_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      sc_result_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (hit_now || state_next != state_reg) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == S_FETCH || state_reg == S_MEM) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
      if (irwen_c) begin
        op_reg    <= instruction[31:26];
        funct_reg <= instruction[5:0];
      end
      if (state_next == S_HALTED) halt_reg <= 1'b1;
      if (timeout_fire) timeout_err_reg <= 1'b1;
      if (state_reg == S_EXEC && is_sc) sc_result_reg <= sc_ok;
    end
  end

`ifdef LLSC_EN
  // A new link taking effect in the same cycle as an invalidate keeps the link.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      link_valid_reg <= 1'b0;
      link_addr_reg  <= '0;
    end else if (state_reg == S_MEM && dhit && is_ll) begin
      link_valid_reg <= 1'b1;
      link_addr_reg  <= daddr;
    end else if ((ccinv && ccsnoopaddr == link_addr_reg) ||
                 (state_reg == S_MEM && dhit && is_sw && daddr == link_addr_reg) ||
                 (state_reg == S_EXEC && is_sc)) begin
      link_valid_reg <= 1'b0;
    end
  end
`endif

  assign iREN        = iren_c & nRST;
  assign dREN        = dren_c & nRST;
  assign dWEN        = dwen_c & nRST;
  assign IRWEN       = irwen_c & nRST;
  assign PCWEN       = pcwen_c & nRST;
  assign RegWEN      = regwen_c & nRST;
  assign MemtoReg    = memtoreg_dec;
  assign ALUsrc      = alusrc_dec;
  assign Regdst      = regdst_dec;
  assign jsel        = (state_reg == S_DECODE || state_reg == S_EXEC) ? jsel_dec : 3'd0;
  assign aluop       = aluop_dec;
  assign bne         = (op_reg == OP_BNE);
  assign sc_result   = sc_result_reg;
  assign halt        = halt_reg;
  assign timeout_err = timeout_err_reg;
  assign state       = state_reg;
endmodule
